// File: rtl/zoom_sequencer.sv
// zoom_sequencer
// Sequences the 2x zoom datapath for one decoded instruction. On an accepted
// start it latches the algorithm select and walks the image in row-major
// order. It issues source reads and destination writes over two req/ack
// ports, and accumulates four pixels for block averaging. It pulses zoom_done
// when the last write completes.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start, ch           run request and algorithm select (sampled in IDLE)
//   busy                high in every state except IDLE
//   zoom_done, err      one-cycle completion pulse / invalid-select flag
//   rd_req/rd_addr      source read request and address (y*SRC_W + x)
//   rd_ack/rd_data      read accepted, data valid in the same cycle
//   wr_req/wr_addr      destination write request and address
//   wr_data/wr_ack      destination pixel and write accepted
module zoom_sequencer #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        ch,
  output logic              busy,
  output logic              zoom_done,
  output logic              err,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  input  logic              wr_ack
);

  localparam logic [ADDR_W-1:0] W_1X   = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] W_2X   = ADDR_W'(2 * SRC_W);
  localparam logic [ADDR_W-1:0] W_HALF = ADDR_W'(SRC_W / 2);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_ADV,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [1:0]          r_ch;
  logic [ADDR_W-1:0]   r_x;
  logic [ADDR_W-1:0]   r_y;
  logic [1:0]          r_k;
  logic [PIX_W+1:0]    r_sum;
  logic [PIX_W-1:0]    r_wr_data;
  logic                r_err;

  logic [ADDR_W-1:0]   w_rd_calc;
  logic [ADDR_W-1:0]   w_wr_calc;
  logic [ADDR_W-1:0]   w_last_x;
  logic [ADDR_W-1:0]   w_last_y;
  logic [ADDR_W-1:0]   w_k0;
  logic [ADDR_W-1:0]   w_k1;
  logic [PIX_W+1:0]    w_sum_next;

  assign w_k0       = ADDR_W'(r_k[0]);
  assign w_k1       = ADDR_W'(r_k[1]);
  assign w_sum_next = r_sum + {2'b00, rd_data};

  // Grid extents and addresses decoded from the latched mode and counters.
  // k selects the sub-pixel of the 2x2 block in modes 1 and 3.
  always_comb begin
    w_rd_calc = '0;
    w_wr_calc = '0;
    w_last_x  = '0;
    w_last_y  = '0;
    case (r_ch)
      2'd0: begin
        w_last_x  = ADDR_W'(2 * SRC_W - 1);
        w_last_y  = ADDR_W'(2 * SRC_H - 1);
        w_rd_calc = (r_y >> 1) * W_1X + (r_x >> 1);
        w_wr_calc = r_y * W_2X + r_x;
      end
      2'd1: begin
        w_last_x  = ADDR_W'(SRC_W - 1);
        w_last_y  = ADDR_W'(SRC_H - 1);
        w_rd_calc = r_y * W_1X + r_x;
        w_wr_calc = ((r_y << 1) + w_k1) * W_2X + (r_x << 1) + w_k0;
      end
      2'd2: begin
        w_last_x  = ADDR_W'(SRC_W / 2 - 1);
        w_last_y  = ADDR_W'(SRC_H / 2 - 1);
        w_rd_calc = (r_y << 1) * W_1X + (r_x << 1);
        w_wr_calc = r_y * W_HALF + r_x;
      end
      default: begin
        w_last_x  = ADDR_W'(SRC_W / 2 - 1);
        w_last_y  = ADDR_W'(SRC_H / 2 - 1);
        w_rd_calc = ((r_y << 1) + w_k1) * W_1X + (r_x << 1) + w_k0;
        w_wr_calc = r_y * W_HALF + r_x;
      end
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign zoom_done = (r_state == S_DONE);
  assign err       = r_err;
  assign rd_req    = (r_state == S_READ);
  assign wr_req    = (r_state == S_WRITE);
  // Addresses are forced to zero outside their request state so that reset
  // and idle present all-zero outputs.
  assign rd_addr   = rd_req ? w_rd_calc : '0;
  assign wr_addr   = wr_req ? w_wr_calc : '0;
  assign wr_data   = r_wr_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ch      <= 2'd0;
      r_x       <= '0;
      r_y       <= '0;
      r_k       <= 2'd0;
      r_sum     <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (ch[2]) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ch    <= ch[1:0];
              r_x     <= '0;
              r_y     <= '0;
              r_k     <= 2'd0;
              r_sum   <= '0;
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (rd_ack) begin
            if (r_ch == 2'd3) begin
              r_sum <= w_sum_next;
              if (r_k == 2'd3) begin
                r_k       <= 2'd0;
                r_wr_data <= w_sum_next[PIX_W+1:2];
                r_state   <= S_WRITE;
              end else begin
                r_k <= r_k + 2'd1;
              end
            end else begin
              r_wr_data <= rd_data;
              r_state   <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (wr_ack) begin
            if (r_ch == 2'd1 && r_k != 2'd3) begin
              r_k <= r_k + 2'd1;
            end else begin
              r_k     <= 2'd0;
              r_state <= S_ADV;
            end
          end
        end
        S_ADV: begin
          r_sum <= '0;
          if (r_x == w_last_x) begin
            r_x <= '0;
            if (r_y == w_last_y) begin
              r_y     <= '0;
              r_state <= S_DONE;
            end else begin
              r_y     <= r_y + ONE;
              r_state <= S_READ;
            end
          end else begin
            r_x     <= r_x + ONE;
            r_state <= S_READ;
          end
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zoom_sequencer.sv
// Self-checking bench for zoom_sequencer on a 4x2 source image.
module tb_zoom_sequencer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int PW    = 8;
  localparam int AW    = 8;
  localparam int LIMIT = 2000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    ch = 3'd0;
  logic          busy, zoom_done, err;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_ack = 1'b0;
  logic          wr_ack = 1'b0;
  logic [PW-1:0] rd_data;
  logic [PW-1:0] wr_data;

  logic [7:0] src_mem [0:7];

  int checks = 0;
  int failures = 0;

  int rd_q[$];
  int wa_q[$];
  int wd_q[$];
  int exp_rd[$];
  int exp_wa[$];
  int exp_wd[$];

  bit      stall_en = 1'b0;
  bit      req_seen = 1'b0;
  int      rd_wait = 0;
  int      wr_wait = 0;
  bit      rd_pend = 1'b0;
  bit      wr_pend = 1'b0;
  logic [AW-1:0] prev_rd_addr = '0;
  logic [AW-1:0] prev_wr_addr = '0;
  logic [PW-1:0] prev_wr_data = '0;

  zoom_sequencer #(
    .SRC_W (W),
    .SRC_H (H),
    .PIX_W (PW),
    .ADDR_W(AW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .ch       (ch),
    .busy     (busy),
    .zoom_done(zoom_done),
    .err      (err),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack)
  );

  always #5 clock = ~clock;

  assign rd_data = src_mem[rd_addr[2:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Memory-side responder: decides acks for the coming edge, logs every
  // transfer and checks request stability across stalls.
  always @(negedge clock) begin
    if (reset) begin
      rd_ack  = 1'b0;
      wr_ack  = 1'b0;
      rd_pend = 1'b0;
      wr_pend = 1'b0;
    end else begin
      if (rd_req || wr_req) req_seen = 1'b1;
      if (rd_req && rd_pend) chk("rd_addr_stable", 32'(rd_addr), 32'(prev_rd_addr));
      if (wr_req && wr_pend) begin
        chk("wr_addr_stable", 32'(wr_addr), 32'(prev_wr_addr));
        chk("wr_data_stable", 32'(wr_data), 32'(prev_wr_data));
      end
      if (!stall_en) rd_ack = 1'b1;
      else if (rd_req) begin
        if (rd_wait > 0) begin rd_ack = 1'b0; rd_wait--; end
        else rd_ack = 1'b1;
      end else rd_ack = 1'($urandom_range(0, 1));
      if (!stall_en) wr_ack = 1'b1;
      else if (wr_req) begin
        if (wr_wait > 0) begin wr_ack = 1'b0; wr_wait--; end
        else wr_ack = 1'b1;
      end else wr_ack = 1'($urandom_range(0, 1));
      if (rd_req && rd_ack) begin
        rd_q.push_back(int'(rd_addr));
        rd_pend = 1'b0;
        rd_wait = int'($urandom_range(0, 3));
      end else begin
        rd_pend = rd_req;
        prev_rd_addr = rd_addr;
      end
      if (wr_req && wr_ack) begin
        wa_q.push_back(int'(wr_addr));
        wd_q.push_back(int'(wr_data));
        wr_pend = 1'b0;
        wr_wait = int'($urandom_range(0, 3));
      end else begin
        wr_pend = wr_req;
        prev_wr_addr = wr_addr;
        prev_wr_data = wr_data;
      end
    end
  end

  task automatic fill_src();
    for (int i = 0; i < 8; i++) src_mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Reference transfer lists computed directly from the zoom rules.
  task automatic build_model(input int mode);
    int a;
    int s;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    case (mode)
      0: for (int y = 0; y < 2*H; y++) for (int x = 0; x < 2*W; x++) begin
           a = (y/2)*W + x/2;
           exp_rd.push_back(a);
           exp_wa.push_back(y*2*W + x);
           exp_wd.push_back(int'(src_mem[a]));
         end
      1: for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) begin
           a = y*W + x;
           exp_rd.push_back(a);
           for (int k = 0; k < 4; k++) begin
             exp_wa.push_back((2*y + k/2)*2*W + 2*x + k%2);
             exp_wd.push_back(int'(src_mem[a]));
           end
         end
      2: for (int y = 0; y < H/2; y++) for (int x = 0; x < W/2; x++) begin
           a = 2*y*W + 2*x;
           exp_rd.push_back(a);
           exp_wa.push_back(y*(W/2) + x);
           exp_wd.push_back(int'(src_mem[a]));
         end
      3: for (int y = 0; y < H/2; y++) for (int x = 0; x < W/2; x++) begin
           s = 0;
           for (int k = 0; k < 4; k++) begin
             a = (2*y + k/2)*W + 2*x + k%2;
             exp_rd.push_back(a);
             s += int'(src_mem[a]);
           end
           exp_wa.push_back(y*(W/2) + x);
           exp_wd.push_back(s/4);
         end
      default: ;
    endcase
  endtask

  task automatic run_op(input string name, input int mode, input bit stall, input int exp_cyc,
                        input bit busy_start, input bit done_start);
    int n;
    int m;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    req_seen = 1'b0;
    stall_en = stall;
    rd_wait  = int'($urandom_range(0, 3));
    wr_wait  = int'($urandom_range(0, 3));
    build_model(mode);
    @(negedge clock);
    start = 1'b1;
    ch    = 3'(mode);
    @(negedge clock);
    start = 1'b0;
    ch    = 3'($urandom_range(0, 7));
    n = 1;
    chk({name, "_busy_rise"}, 32'(busy), 32'd1);
    while (!zoom_done && n < LIMIT) begin
      @(negedge clock);
      n++;
      if (busy_start) begin
        if (n == 3) begin start = 1'b1; ch = 3'd0; end
        else if (n == 4) start = 1'b0;
      end
    end
    chk({name, "_done_seen"}, 32'(zoom_done), 32'd1);
    if (exp_cyc > 0) chk({name, "_done_cycle"}, 32'(n), 32'(exp_cyc));
    chk({name, "_err"}, 32'(err), (mode >= 4) ? 32'd1 : 32'd0);
    if (done_start) begin start = 1'b1; ch = 3'd1; end
    @(negedge clock);
    start = 1'b0;
    chk({name, "_busy_fall"}, 32'(busy), 32'd0);
    chk({name, "_done_pulse"}, 32'(zoom_done), 32'd0);
    chk({name, "_rd_count"}, 32'(rd_q.size()), 32'(exp_rd.size()));
    chk({name, "_wr_count"}, 32'(wa_q.size()), 32'(exp_wa.size()));
    m = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
    for (int i = 0; i < m; i++) chk({name, "_rd_addr"}, 32'(rd_q[i]), 32'(exp_rd[i]));
    m = (wa_q.size() < exp_wa.size()) ? wa_q.size() : exp_wa.size();
    for (int i = 0; i < m; i++) begin
      chk({name, "_wr_addr"}, 32'(wa_q[i]), 32'(exp_wa[i]));
      chk({name, "_wr_data"}, 32'(wd_q[i]), 32'(exp_wd[i]));
    end
    if (mode >= 4) chk({name, "_no_req"}, 32'(req_seen), 32'd0);
    $display("op %s mode=%0d stall=%0d cycles=%0d reads=%0d writes=%0d",
             name, mode, stall, n, rd_q.size(), wa_q.size());
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int idx;
    int n;
    fill_src();
    #1;
    chk("reset_outputs", 32'({busy, zoom_done, err, rd_req, wr_req, rd_addr, wr_addr, wr_data}), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Decimation, acks high; a start during DONE must be ignored.
    run_op("mode2", 2, 1'b0, 7, 1'b0, 1'b1);

    // Block average with known values: (10+20+30+41)>>2 = 25.
    src_mem[0] = 8'd10; src_mem[1] = 8'd20; src_mem[4] = 8'd30; src_mem[5] = 8'd41;
    run_op("mode3", 3, 1'b0, 13, 1'b0, 1'b0);
    chk("mode3_first_wr_addr", 32'(q_at(wa_q, 0)), 32'd0);
    chk("mode3_first_wr_data", 32'(q_at(wd_q, 0)), 32'd25);
    chk("mode3_px1_rd0", 32'(q_at(rd_q, 4)), 32'd2);
    chk("mode3_px1_rd1", 32'(q_at(rd_q, 5)), 32'd3);
    chk("mode3_px1_rd2", 32'(q_at(rd_q, 6)), 32'd6);
    chk("mode3_px1_rd3", 32'(q_at(rd_q, 7)), 32'd7);

    // Replication.
    fill_src();
    src_mem[0] = 8'hAB;
    run_op("mode1", 1, 1'b0, 49, 1'b0, 1'b0);
    chk("mode1_wr0", 32'(q_at(wa_q, 0)), 32'd0);
    chk("mode1_wr1", 32'(q_at(wa_q, 1)), 32'd1);
    chk("mode1_wr2", 32'(q_at(wa_q, 2)), 32'd8);
    chk("mode1_wr3", 32'(q_at(wa_q, 3)), 32'd9);
    for (int i = 0; i < 4; i++) chk("mode1_wr_data_ab", 32'(q_at(wd_q, i)), 32'hAB);

    // Nearest-neighbour, acks high then randomly stalled.
    fill_src();
    run_op("mode0", 0, 1'b0, 97, 1'b0, 1'b0);
    fill_src();
    run_op("mode0_stall", 0, 1'b1, 0, 1'b0, 1'b0);
    idx = -1;
    for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] == 11 && idx < 0) idx = i;
    chk("mode0_addr11_found", 32'(idx >= 0), 32'd1);
    if (idx >= 0) chk("mode0_addr11_data", 32'(wd_q[idx]), 32'(src_mem[1]));

    // Invalid select.
    run_op("invalid5", 5, 1'b0, 1, 1'b0, 1'b0);

    // Block average under random stalls.
    fill_src();
    run_op("mode3_stall", 3, 1'b1, 0, 1'b0, 1'b0);

    // Reset in the middle of a mode 0 write.
    stall_en = 1'b0;
    @(negedge clock);
    start = 1'b1;
    ch    = 3'd0;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!wr_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("reset_mid_write_reached", 32'(wr_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_mid_outputs", 32'({busy, zoom_done, err, rd_req, wr_req, rd_addr, wr_addr, wr_data}), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    fill_src();
    run_op("mode2_after_reset", 2, 1'b0, 7, 1'b1, 1'b0);
    chk("after_reset_first_rd", 32'(q_at(rd_q, 0)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
